// File: rtl/mu0_phase_sequencer_pkg.sv
// Shared encodings for the MU0 phase sequencer: FSM states, opcode constants, phase strobe bundle.
package mu0_phase_sequencer_pkg;

  localparam int unsigned STATE_W = 3;
  localparam int unsigned OP_W    = 4;

  localparam logic [STATE_W-1:0] ST_PAUSE = 3'd0;
  localparam logic [STATE_W-1:0] ST_FETCH = 3'd1;
  localparam logic [STATE_W-1:0] ST_EXEC1 = 3'd2;
  localparam logic [STATE_W-1:0] ST_EXEC2 = 3'd3;
  localparam logic [STATE_W-1:0] ST_HALT  = 3'd4;

  localparam logic [OP_W-1:0] OP_LDA = 4'h0;
  localparam logic [OP_W-1:0] OP_STA = 4'h1;
  localparam logic [OP_W-1:0] OP_ADD = 4'h2;
  localparam logic [OP_W-1:0] OP_SUB = 4'h3;
  localparam logic [OP_W-1:0] OP_JMP = 4'h4;
  localparam logic [OP_W-1:0] OP_JGE = 4'h5;
  localparam logic [OP_W-1:0] OP_JNE = 4'h6;
  localparam logic [OP_W-1:0] OP_STP = 4'h7;
  localparam logic [OP_W-1:0] OP_AND = 4'h8;
  localparam logic [OP_W-1:0] OP_LSL = 4'h9;
  localparam logic [OP_W-1:0] OP_LSR = 4'hA;
  localparam logic [OP_W-1:0] OP_ILLEGAL_MIN = 4'hB;

  typedef struct packed {
    logic fetch;
    logic exec1;
    logic exec2;
  } phase_t;

  // Opcodes above the defined set halt the core with ILLEGAL raised.
  function automatic logic is_illegal(input logic [OP_W-1:0] op);
    return op >= OP_ILLEGAL_MIN;
  endfunction

endpackage

// File: rtl/mu0_event_counter.sv
// Wrapping event counter with synchronous clear; used for retired-instruction and active-cycle counts.
module mu0_event_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] count_o
);

  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      count_q <= '0;
    end else if (inc_i) begin
      count_q <= count_q + CNT_W'(1);
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/mu0_phase_sequencer.sv
// MU0 phase sequencer: one-hot FETCH/EXEC1/EXEC2 strobes with run/pause, single-step and halt control.
module mu0_phase_sequencer
  import mu0_phase_sequencer_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             run_i,
  input  logic             step_req_i,
  input  logic             restart_i,
  input  logic [OP_W-1:0]  op_i,
  input  logic             extra_i,
  output logic             fetch_o,
  output logic             exec1_o,
  output logic             exec2_o,
  output logic             step_ack_o,
  output logic             halted_o,
  output logic             illegal_o,
  output logic [CNT_W-1:0] instr_cnt_o,
  output logic [CNT_W-1:0] cycle_cnt_o
);

  logic [STATE_W-1:0] state_q, state_d;
  phase_t             phase_q, phase_d;
  logic               step_pending_q, step_pending_d;
  logic               step_ack_q, step_ack_d;
  logic               halted_q, halted_d;
  logic               illegal_q, illegal_d;
  logic               boundary_c;
  logic               instr_inc_c;
  logic               cycle_inc_c;

  // Next-state, step bookkeeping and flag updates.
  always_comb begin
    state_d        = state_q;
    step_pending_d = step_pending_q;
    illegal_d      = illegal_q;
    step_ack_d     = 1'b0;
    boundary_c     = 1'b0;
    instr_inc_c    = 1'b0;

    case (state_q)
      ST_PAUSE: begin
        if (run_i) begin
          state_d = ST_FETCH;
        end else if (step_req_i) begin
          state_d        = ST_FETCH;
          step_pending_d = 1'b1;
        end
      end
      ST_FETCH: state_d = ST_EXEC1;
      ST_EXEC1: begin
        if (op_i == OP_STP) begin
          state_d        = ST_HALT;
          instr_inc_c    = 1'b1;
          step_pending_d = 1'b0;
        end else if (is_illegal(op_i)) begin
          state_d        = ST_HALT;
          illegal_d      = 1'b1;
          step_pending_d = 1'b0;
        end else if (extra_i) begin
          state_d = ST_EXEC2;
        end else begin
          boundary_c = 1'b1;
        end
      end
      ST_EXEC2: boundary_c = 1'b1;
      ST_HALT: begin
        if (restart_i) begin
          state_d        = ST_PAUSE;
          illegal_d      = 1'b0;
          step_pending_d = 1'b0;
        end
      end
      default: state_d = ST_PAUSE;
    endcase

    // A pending step wins over RUN so the stepped instruction is always acknowledged.
    if (boundary_c) begin
      instr_inc_c = 1'b1;
      if (step_pending_q) begin
        state_d        = ST_PAUSE;
        step_ack_d     = 1'b1;
        step_pending_d = 1'b0;
      end else if (run_i) begin
        state_d = ST_FETCH;
      end else begin
        state_d = ST_PAUSE;
      end
    end

    phase_d.fetch = (state_d == ST_FETCH);
    phase_d.exec1 = (state_d == ST_EXEC1);
    phase_d.exec2 = (state_d == ST_EXEC2);
    halted_d      = (state_d == ST_HALT);
  end

  assign cycle_inc_c = (state_q == ST_FETCH) || (state_q == ST_EXEC1) || (state_q == ST_EXEC2);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q        <= ST_PAUSE;
      phase_q        <= '0;
      step_pending_q <= 1'b0;
      step_ack_q     <= 1'b0;
      halted_q       <= 1'b0;
      illegal_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      phase_q        <= phase_d;
      step_pending_q <= step_pending_d;
      step_ack_q     <= step_ack_d;
      halted_q       <= halted_d;
      illegal_q      <= illegal_d;
    end
  end

  mu0_event_counter #(.CNT_W(CNT_W)) u_instr_cnt (
    .clk_i   (clk_i),
    .clr_i   (reset_i),
    .inc_i   (instr_inc_c),
    .count_o (instr_cnt_o)
  );

  mu0_event_counter #(.CNT_W(CNT_W)) u_cycle_cnt (
    .clk_i   (clk_i),
    .clr_i   (reset_i),
    .inc_i   (cycle_inc_c),
    .count_o (cycle_cnt_o)
  );

  assign fetch_o    = phase_q.fetch;
  assign exec1_o    = phase_q.exec1;
  assign exec2_o    = phase_q.exec2;
  assign step_ack_o = step_ack_q;
  assign halted_o   = halted_q;
  assign illegal_o  = illegal_q;

endmodule
